// File: rtl/llc_elastic_pipe_reg.sv
// llc_elastic_pipe_reg
//   DEPTH-entry elastic pipeline register (skid buffer) for the LLC pipeline.
//   The upstream ready is a function of the registered occupancy only. This
//   breaks the combinational ready chain between neighbouring LLC stages,
//   while still allowing one transfer per cycle.
//
//   Optional build feature:
//     LLC_ELASTIC_PIPE_REG_STALL_CNT_EN - adds the 32-bit saturating stall_cnt
//     output. It counts cycles where valid_out=1 and ready_in=0, and is used
//     for back-pressure profiling.
//
//   Handshake semantics (both sides):
//     - A transfer happens on a rising clk edge where valid and ready are both 1.
//     - Once valid_out is raised, it and data_out stay stable until the
//       transfer completes.
//     - valid_in/data_in may change freely. They are only sampled when
//       ready_out=1.
//     - ready_in may be asserted at any time. It is ignored while the buffer
//       is empty.
//     - flush overrides both sides for that edge: the push and the pop are
//       both dropped.
module llc_elastic_pipe_reg #(
  parameter int  DATA_WIDTH = 32,
  parameter type dtype      = logic [DATA_WIDTH-1:0],
  parameter int  DEPTH      = 2,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             valid_in,
  output logic             ready_out,
  input  dtype             data_in,
  output logic             valid_out,
  input  logic             ready_in,
  output dtype             data_out,
  output logic [CNT_W-1:0] count
`ifdef LLC_ELASTIC_PIPE_REG_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  // Pointer width covers indices 0..DEPTH-1. DEPTH need not be a power of 2,
  // so the pointers wrap by an explicit compare against the last index.
  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  dtype             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push;
  logic             pop;

  // Both handshake flags come straight from the registered count. There is no
  // path from ready_in or valid_in to ready_out.
  assign ready_out = (count_q != FULL_CNT);
  assign valid_out = (count_q != '0);
  assign data_out  = mem_q[rd_ptr_q];
  assign count     = count_q;

  assign push = valid_in  && ready_out;
  assign pop  = valid_out && ready_in;

  // Next-state for the pointers and occupancy. Flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage. Reset clears it so that data_out reads '0 out of reset. Flush
  // only drops the write of the flushed cycle; older contents are left as
  // they were and become unreachable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

`ifdef LLC_ELASTIC_PIPE_REG_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where the head is held back by downstream; saturate at the top.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      stall_cnt_d = '0;
    end else if (valid_out && !ready_in && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_llc_elastic_pipe_reg.sv
// Bench for llc_elastic_pipe_reg: three instances (DEPTH 2, 3 and 4) share
// clk/rst. A per-instance occupancy model and expected-data queue predict the
// outputs every cycle.
module tb_llc_elastic_pipe_reg;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Per-instance signals: index 0 -> DEPTH=2, 1 -> DEPTH=3, 2 -> DEPTH=4.
  logic          flush_0, valid_in_0, ready_in_0, valid_out_0, ready_out_0;
  logic [DW-1:0] data_in_0, data_out_0;
  logic [1:0]    count_0;
  logic          flush_1, valid_in_1, ready_in_1, valid_out_1, ready_out_1;
  logic [DW-1:0] data_in_1, data_out_1;
  logic [1:0]    count_1;
  logic          flush_2, valid_in_2, ready_in_2, valid_out_2, ready_out_2;
  logic [DW-1:0] data_in_2, data_out_2;
  logic [2:0]    count_2;
`ifdef LLC_ELASTIC_PIPE_REG_STALL_CNT_EN
  logic [31:0]   stall_cnt_0, stall_cnt_1, stall_cnt_2;
  logic [31:0]   mstall;
`endif

  llc_elastic_pipe_reg #(.DATA_WIDTH(DW), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush_0),
    .valid_in(valid_in_0), .ready_out(ready_out_0), .data_in(data_in_0),
    .valid_out(valid_out_0), .ready_in(ready_in_0), .data_out(data_out_0),
    .count(count_0)
`ifdef LLC_ELASTIC_PIPE_REG_STALL_CNT_EN
    , .stall_cnt(stall_cnt_0)
`endif
  );

  llc_elastic_pipe_reg #(.DATA_WIDTH(DW), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush_1),
    .valid_in(valid_in_1), .ready_out(ready_out_1), .data_in(data_in_1),
    .valid_out(valid_out_1), .ready_in(ready_in_1), .data_out(data_out_1),
    .count(count_1)
`ifdef LLC_ELASTIC_PIPE_REG_STALL_CNT_EN
    , .stall_cnt(stall_cnt_1)
`endif
  );

  llc_elastic_pipe_reg #(.DATA_WIDTH(DW), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .flush(flush_2),
    .valid_in(valid_in_2), .ready_out(ready_out_2), .data_in(data_in_2),
    .valid_out(valid_out_2), .ready_in(ready_in_2), .data_out(data_out_2),
    .count(count_2)
`ifdef LLC_ELASTIC_PIPE_REG_STALL_CNT_EN
    , .stall_cnt(stall_cnt_2)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q0[$], exp_q1[$], exp_q2[$];
  int mcnt [3];
  int depth_of [3] = '{2, 3, 4};
  int n_checks = 0;
  int n_errors = 0;

  task automatic clear_models();
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
`ifdef LLC_ELASTIC_PIPE_REG_STALL_CNT_EN
    mstall = '0;
`endif
  endtask

  // ---------------- driver / checker: one clock cycle on instance k ----------------
  // Called just after a falling edge. It drives inputs, checks the outputs
  // against the model, updates the model for the coming rising edge, and then
  // waits for the next falling edge.
  task automatic step(input int k, input logic v, input logic [DW-1:0] d,
                      input logic r, input logic f);
    logic          vo, ro, exp_v, exp_r, push, pop;
    logic [DW-1:0] dout, head;
    int            cobs;
    vo = 1'b0; ro = 1'b0; dout = '0; cobs = 0; head = '0;
    case (k)
      0:       begin valid_in_0 = v; data_in_0 = d; ready_in_0 = r; flush_0 = f; end
      1:       begin valid_in_1 = v; data_in_1 = d; ready_in_1 = r; flush_1 = f; end
      default: begin valid_in_2 = v; data_in_2 = d; ready_in_2 = r; flush_2 = f; end
    endcase
    #1;
    case (k)
      0:       begin vo = valid_out_0; ro = ready_out_0; dout = data_out_0; cobs = int'(count_0); end
      1:       begin vo = valid_out_1; ro = ready_out_1; dout = data_out_1; cobs = int'(count_1); end
      default: begin vo = valid_out_2; ro = ready_out_2; dout = data_out_2; cobs = int'(count_2); end
    endcase
    exp_v = (mcnt[k] != 0);
    exp_r = (mcnt[k] != depth_of[k]);
    n_checks++;
    if (vo !== exp_v) begin
      n_errors++;
      $display("FAIL valid_out d%0d t=%0t: got %b expected %b", depth_of[k], $time, vo, exp_v);
    end
    n_checks++;
    if (ro !== exp_r) begin
      n_errors++;
      $display("FAIL ready_out d%0d t=%0t: got %b expected %b", depth_of[k], $time, ro, exp_r);
    end
    n_checks++;
    if (cobs != mcnt[k]) begin
      n_errors++;
      $display("FAIL count d%0d t=%0t: got %0d expected %0d", depth_of[k], $time, cobs, mcnt[k]);
    end
    if (exp_v) begin
      case (k)
        0:       head = exp_q0[0];
        1:       head = exp_q1[0];
        default: head = exp_q2[0];
      endcase
      n_checks++;
      if (dout !== head) begin
        n_errors++;
        $display("FAIL data_out d%0d t=%0t: got %h expected %h", depth_of[k], $time, dout, head);
      end
    end
`ifdef LLC_ELASTIC_PIPE_REG_STALL_CNT_EN
    if (k == 2) begin
      n_checks++;
      if (stall_cnt_2 !== mstall) begin
        n_errors++;
        $display("FAIL stall_cnt t=%0t: got %0d expected %0d", $time, stall_cnt_2, mstall);
      end
      if (f) mstall = '0;
      else if (exp_v && !r && mstall != 32'hFFFF_FFFF) mstall = mstall + 32'd1;
    end
`endif
    push = v && exp_r && !f;
    pop  = exp_v && r && !f;
    if (f) begin
      mcnt[k] = 0;
      case (k)
        0:       exp_q0.delete();
        1:       exp_q1.delete();
        default: exp_q2.delete();
      endcase
    end else begin
      if (pop) begin
        case (k)
          0:       void'(exp_q0.pop_front());
          1:       void'(exp_q1.pop_front());
          default: void'(exp_q2.pop_front());
        endcase
      end
      if (push) begin
        case (k)
          0:       exp_q0.push_back(d);
          1:       exp_q1.push_back(d);
          default: exp_q2.push_back(d);
        endcase
      end
      mcnt[k] = mcnt[k] + int'(push) - int'(pop);
    end
    @(negedge clk);
    case (k)
      0:       begin valid_in_0 = 1'b0; flush_0 = 1'b0; end
      1:       begin valid_in_1 = 1'b0; flush_1 = 1'b0; end
      default: begin valid_in_2 = 1'b0; flush_2 = 1'b0; end
    endcase
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 8 && mcnt[k] != 0; i++) step(k, 1'b0, '0, 1'b1, 1'b0);
    step(k, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_checks++;
    if (valid_out_0 !== 1'b0 || valid_out_1 !== 1'b0 || valid_out_2 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset valid_out: got %b%b%b expected 000", valid_out_0, valid_out_1, valid_out_2);
    end
    n_checks++;
    if (ready_out_0 !== 1'b1 || ready_out_1 !== 1'b1 || ready_out_2 !== 1'b1) begin
      n_errors++;
      $display("FAIL reset ready_out: got %b%b%b expected 111", ready_out_0, ready_out_1, ready_out_2);
    end
    n_checks++;
    if (count_0 !== 2'd0 || count_1 !== 2'd0 || count_2 !== 3'd0) begin
      n_errors++;
      $display("FAIL reset count: got %0d %0d %0d expected 0 0 0", count_0, count_1, count_2);
    end
    n_checks++;
    if (data_out_0 !== '0 || data_out_1 !== '0 || data_out_2 !== '0) begin
      n_errors++;
      $display("FAIL reset data_out: got %h %h %h expected 0", data_out_0, data_out_1, data_out_2);
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 20; i++) step(0, 1'b1, DW'(i), 1'b1, 1'b0);
    drain(0);
  endtask

  task automatic test_fill_stall_drain();
    for (int i = 0; i < 6; i++) step(2, 1'b1, 32'hA0 + DW'(i), 1'b0, 1'b0);
    // Full with ready_in=1: no push this cycle; 0xA4 is accepted one cycle later.
    step(2, 1'b1, 32'hA4, 1'b1, 1'b0);
    step(2, 1'b1, 32'hA4, 1'b1, 1'b0);
    drain(2);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++)
      step(1, 1'b1, DW'($urandom_range(0, 32'hFFFF)) | (DW'(i) << 24), (i % 2) == 0, 1'b0);
    drain(1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(2, 1'b1, 32'hF0 + DW'(i), 1'b0, 1'b0);
    step(2, 1'b1, 32'hDEAD, 1'b1, 1'b1);
    step(2, 1'b1, 32'h55, 1'b0, 1'b0);
    drain(2);
  endtask

  task automatic test_reset_mid();
    step(2, 1'b1, 32'h31, 1'b0, 1'b0);
    step(2, 1'b1, 32'h32, 1'b0, 1'b0);
    step(2, 1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (valid_out_2 !== 1'b0 || count_2 !== 3'd0 || ready_out_2 !== 1'b1 || data_out_2 !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got v=%b c=%0d r=%b d=%h expected v=0 c=0 r=1 d=0",
               valid_out_2, count_2, ready_out_2, data_out_2);
    end
    clear_models();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    step(2, 1'b1, 32'h77, 1'b0, 1'b0);
    step(2, 1'b0, '0, 1'b1, 1'b0);
    step(2, 1'b0, '0, 1'b0, 1'b0);
  endtask

`ifdef LLC_ELASTIC_PIPE_REG_STALL_CNT_EN
  task automatic test_stall_cnt();
    step(2, 1'b1, 32'h11, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(2, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (stall_cnt_2 !== 32'd5) begin
      n_errors++;
      $display("FAIL stall_cnt_5: got %0d expected 5", stall_cnt_2);
    end
    step(2, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (stall_cnt_2 !== 32'd0) begin
      n_errors++;
      $display("FAIL stall_cnt_flush: got %0d expected 0", stall_cnt_2);
    end
    step(2, 1'b0, '0, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++)
      step(2, 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 31) == 0);
    drain(2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    {flush_0, valid_in_0, ready_in_0} = '0; data_in_0 = '0;
    {flush_1, valid_in_1, ready_in_1} = '0; data_in_1 = '0;
    {flush_2, valid_in_2, ready_in_2} = '0; data_in_2 = '0;
    clear_models();
    repeat (2) @(negedge clk);
    #1 test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_streaming();
    test_fill_stall_drain();
    test_wrap();
    test_flush();
    test_reset_mid();
`ifdef LLC_ELASTIC_PIPE_REG_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
